// File: rtl/alu_sequencer_if.sv
// Command and response channels between a producer/consumer and the ALU sequencer.
interface alu_sequencer_if #(
  parameter int DW  = 8,
  parameter int RAW = 2
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic           cmd_load;
  logic [2:0]     cmd_op;
  logic [RAW-1:0] cmd_dst;
  logic [RAW-1:0] cmd_srca;
  logic [RAW-1:0] cmd_srcb;
  logic           cmd_use_imm;
  logic [DW-1:0]  cmd_imm;

  logic           rsp_valid;
  logic           rsp_ready;
  logic [DW-1:0]  rsp_data;
  logic [RAW-1:0] rsp_dst;
  logic           rsp_dz;

  // Producer of commands, consumer of responses.
  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_use_imm, cmd_imm,
    output rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_dst, rsp_dz
  );

  // The sequencer side.
  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_use_imm, cmd_imm,
    input  rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_dst, rsp_dz
  );
endinterface

// File: rtl/alu_sequencer.sv
// Register-file sequencer wrapped around an external combinational ALU.
// One command in flight at a time: IDLE accepts, ISSUE lets the ALU settle,
// RESP holds the result until the consumer takes it.
module alu_sequencer #(
  parameter int             DW       = 8,
  parameter int             RAW      = 2,
  parameter logic [DW-1:0]  DZ_VALUE = '1
) (
  input  logic          CLK,
  input  logic          RST,
  alu_sequencer_if.slave bus,
  output logic [DW-1:0] ALU_A,
  output logic [DW-1:0] ALU_B,
  output logic [2:0]    ALU_SEL,
  input  logic [DW-1:0] ALU_OUT
);
  localparam int NREG = 1 << RAW;
  localparam logic [2:0] OP_DIV = 3'b011;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [RAW-1:0] dst;
    logic           dz;
  } rsp_t;

  state_t                    state, state_n;
  logic [NREG-1:0][DW-1:0]   rf;
  logic [RAW-1:0]            dst_q;
  rsp_t                      rsp_q;
  logic                      cmd_ready, rsp_valid;
  logic                      dz;
  logic [DW-1:0]             result;

  // Zero divisor is caught here so the ALU's own divide behaviour never leaks out.
  assign dz     = (ALU_SEL == OP_DIV) && (ALU_B == '0);
  assign result = dz ? DZ_VALUE : ALU_OUT;

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_q.data;
  assign bus.rsp_dst   = rsp_q.dst;
  assign bus.rsp_dz    = rsp_q.dz;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and handshake outputs; loads skip ISSUE since no ALU result is needed.
  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) state_n = bus.cmd_load ? RESP : ISSUE;
      end
      ISSUE: state_n = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: operand launch on accept, writeback at the end of ISSUE.
  // ALU_* and the response register are only written on those events, so they
  // hold through RESP and IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rf      <= '0;
      ALU_A   <= '0;
      ALU_B   <= '0;
      ALU_SEL <= '0;
      dst_q   <= '0;
      rsp_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_load) begin
              rf[bus.cmd_dst] <= bus.cmd_imm;
              rsp_q           <= '{data: bus.cmd_imm, dst: bus.cmd_dst, dz: 1'b0};
            end else begin
              ALU_A   <= rf[bus.cmd_srca];
              ALU_B   <= bus.cmd_use_imm ? bus.cmd_imm : rf[bus.cmd_srcb];
              ALU_SEL <= bus.cmd_op;
              dst_q   <= bus.cmd_dst;
            end
          end
        end
        ISSUE: begin
          rf[dst_q] <= result;
          rsp_q     <= '{data: result, dst: dst_q, dz: dz};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU, a register-file model and a
// response scoreboard drained by an independent monitor.
module tb_alu_sequencer;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_sel;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] dst;
    logic       dz;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mrf [4];

  alu_sequencer_if #(.DW(8), .RAW(2)) bus ();

  alu_sequencer #(.DW(8), .RAW(2), .DZ_VALUE(8'hFF)) dut (
    .CLK(CLK), .RST(RST), .bus(bus),
    .ALU_A(alu_a), .ALU_B(alu_b), .ALU_SEL(alu_sel), .ALU_OUT(alu_out)
  );

  always #5 CLK = ~CLK;

  // Team 8-bit ALU; divide by zero returns 0 so substitution is visible.
  always_comb begin
    alu_out = 8'h00;
    case (alu_sel)
      3'd0: alu_out = alu_a + alu_b;
      3'd1: alu_out = alu_a - alu_b;
      3'd2: alu_out = alu_a * alu_b;
      3'd3: alu_out = (alu_b == 8'h00) ? 8'h00 : alu_a / alu_b;
      3'd4: alu_out = alu_a & alu_b;
      3'd5: alu_out = alu_a | alu_b;
      3'd6: alu_out = alu_a ^ alu_b;
      default: alu_out = ~(alu_a ^ alu_b);
    endcase
  end

  // Reference arithmetic in plain integers; returns {dz, result}.
  function automatic logic [8:0] ref_alu(input logic [2:0] op, input int a, input int b);
    int   r;
    logic z;
    z = 1'b0;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a * b;
      3'd3: if (b == 0) begin r = 255; z = 1'b1; end else r = a / b;
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = ~(a ^ b);
    endcase
    return {z, r[7:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted response is compared with the oldest expectation.
  always @(negedge CLK) begin
    if (!RST && bus.rsp_valid && bus.rsp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected actual=%0h/%0d/%0d required=none",
                 bus.rsp_data, bus.rsp_dst, bus.rsp_dz);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.rsp_data !== e.data || bus.rsp_dst !== e.dst || bus.rsp_dz !== e.dz) begin
          errors++;
          $display("FAIL rsp actual=%0h/%0d/%0d required=%0h/%0d/%0d",
                   bus.rsp_data, bus.rsp_dst, bus.rsp_dz, e.data, e.dst, e.dz);
        end
      end
    end
  end

  // Present one command, wait for acceptance, then for the response (latency checked).
  task automatic drive_cmd(input bit ld, input logic [2:0] op, input logic [1:0] dst,
                           input logic [1:0] sa, input logic [1:0] sbr, input bit ui,
                           input logic [7:0] imm, input bit expect_rsp);
    exp_t       e;
    logic [8:0] r;
    int         n;
    if (ld) begin
      e = '{data: imm, dst: dst, dz: 1'b0};
    end else begin
      r = ref_alu(op, int'(mrf[sa]), ui ? int'(imm) : int'(mrf[sbr]));
      e = '{data: r[7:0], dst: dst, dz: r[8]};
    end
    bus.cmd_load = ld; bus.cmd_op = op; bus.cmd_dst = dst; bus.cmd_srca = sa;
    bus.cmd_srcb = sbr; bus.cmd_use_imm = ui; bus.cmd_imm = imm; bus.cmd_valid = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!bus.cmd_ready && n < 20) begin n++; @(negedge CLK); end
    if (!bus.cmd_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=cmd_ready0 required=cmd_ready1");
    end
    @(posedge CLK);
    if (expect_rsp) begin
      sb.push_back(e);
      mrf[dst] = e.data;
    end
    #1 bus.cmd_valid = 1'b0;
    if (expect_rsp) begin
      n = 1;
      @(negedge CLK);
      while (!bus.rsp_valid && n < 10) begin n++; @(negedge CLK); end
      check(ld ? "latency_load" : "latency_alu", n, ld ? 1 : 2);
      if (bus.rsp_ready) begin @(posedge CLK); #1; end
    end
  endtask

  task automatic alu(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                     input logic [1:0] sbr, input bit ui, input logic [7:0] imm);
    drive_cmd(1'b0, op, dst, sa, sbr, ui, imm, 1'b1);
  endtask

  task automatic load(input logic [1:0] dst, input logic [7:0] imm);
    drive_cmd(1'b1, 3'd0, dst, 2'd0, 2'd0, 1'b0, imm, 1'b1);
  endtask

  // Register read-back through OR with immediate zero.
  task automatic readback(input logic [1:0] r);
    alu(3'd5, r, r, 2'd0, 1'b1, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] snap;
    bus.cmd_valid = 1'b0; bus.cmd_load = 1'b0; bus.cmd_op = 3'd0; bus.cmd_dst = 2'd0;
    bus.cmd_srca = 2'd0; bus.cmd_srcb = 2'd0; bus.cmd_use_imm = 1'b0; bus.cmd_imm = 8'h00;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) mrf[i] = 8'h00;

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("reset_cmd_ready", bus.cmd_ready, 1);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_alu", {alu_a, alu_b, 5'd0, alu_sel}, 0);
    check("reset_rsp", {bus.rsp_data, 2'd0, bus.rsp_dst, 3'd0, bus.rsp_dz}, 0);
    @(posedge CLK); #1;

    // Wrapping add.
    load(2'd0, 8'd200);
    load(2'd1, 8'd100);
    alu(3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00);
    readback(2'd2);

    // Remaining arithmetic and logic ops.
    alu(3'd1, 2'd3, 2'd1, 2'd0, 1'b0, 8'h00);
    readback(2'd3);
    load(2'd0, 8'd20);
    alu(3'd2, 2'd1, 2'd0, 2'd0, 1'b1, 8'd13);
    readback(2'd1);
    load(2'd0, 8'd200);
    alu(3'd3, 2'd1, 2'd0, 2'd0, 1'b1, 8'd7);
    readback(2'd1);
    load(2'd0, 8'hF0);
    load(2'd1, 8'h0F);
    alu(3'd7, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00);
    readback(2'd3);

    // Divide by zero then a normal divide.
    load(2'd0, 8'd200);
    alu(3'd3, 2'd1, 2'd0, 2'd0, 1'b1, 8'd0);
    readback(2'd1);
    alu(3'd3, 2'd3, 2'd0, 2'd0, 1'b1, 8'd5);

    // Backpressure with a competing command that must not be taken.
    bus.rsp_ready = 1'b0;
    alu(3'd6, 2'd1, 2'd0, 2'd3, 1'b0, 8'h00);
    snap = {bus.rsp_data, bus.rsp_dst, bus.rsp_dz};
    bus.cmd_load = 1'b1; bus.cmd_dst = 2'd0; bus.cmd_imm = 8'd77; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("stall_valid_ready", {bus.rsp_valid, bus.cmd_ready}, 2'b10);
      check("stall_hold", {bus.rsp_data, bus.rsp_dst, bus.rsp_dz}, snap);
    end
    @(posedge CLK);
    #1 bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("release_idle", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    @(posedge CLK); #1;
    readback(2'd0);

    // Self-referencing destination.
    load(2'd3, 8'd9);
    alu(3'd0, 2'd3, 2'd3, 2'd3, 1'b0, 8'h00);
    alu(3'd0, 2'd3, 2'd3, 2'd3, 1'b0, 8'h00);

    // Reset during ISSUE of an ADD into R2.
    drive_cmd(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    for (int i = 0; i < 4; i++) mrf[i] = 8'h00;
    @(negedge CLK);
    check("post_reset_ready_valid", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    check("post_reset_alu", {alu_a, alu_b, 5'd0, alu_sel}, 0);
    @(posedge CLK); #1;
    readback(2'd2);

    // Randomized command stream.
    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      logic [7:0] imm;
      op  = 3'($urandom_range(0, 7));
      imm = 8'($urandom_range(0, 255));
      if (op == 3'd3 && $urandom_range(0, 3) == 0) imm = 8'h00;
      if ($urandom_range(0, 3) == 0)
        load(2'($urandom_range(0, 3)), imm);
      else
        alu(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), imm);
    end

    repeat (3) @(posedge CLK);
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-driven controller on the operand/opcode side of the team's 8-bit combinational ALU.
- Holds a small register file and accepts commands over a valid/ready handshake.
- For each command it drives ALU_A, ALU_B and ALU_SEL from registers, captures ALU_OUT, writes the result back and returns it over a valid/ready response channel.
- Guards the divide opcode against a zero divisor.

Parameters:
- DW, 8: data width; must match the ALU width.
- RAW, 2: register-file address bits (2^RAW registers).
- DZ_VALUE, all ones (8'hFF): result substituted for divide-by-zero.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_load  input  1  1 = write cmd_imm into cmd_dst (no ALU op); 0 = ALU op.
- cmd_op  input  3  ALU opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 XNOR.
- cmd_dst  input  RAW  destination register.
- cmd_srca  input  RAW  A-operand register.
- cmd_srcb  input  RAW  B-operand register.
- cmd_use_imm  input  1  1 = B operand is cmd_imm instead of rf[cmd_srcb].
- cmd_imm  input  DW  immediate.
- ALU_A  output  DW  operand A to ALU.
- ALU_B  output  DW  operand B to ALU.
- ALU_SEL  output  3  opcode to ALU.
- ALU_OUT  input  DW  ALU result (combinational from ALU_A/ALU_B/ALU_SEL).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  DW  result written.
- rsp_dst  output  RAW  register written.
- rsp_dz  output  1  divide-by-zero flag for this response.

Behaviour:
- States: IDLE, ISSUE, RESP.
- Reset (RST=1 at a rising edge): state=IDLE. cmd_ready=1 (combinational from IDLE). ALU_A=0, ALU_B=0, ALU_SEL=000. rsp_valid=0, rsp_data=0, rsp_dst=0, rsp_dz=0. All register-file entries=0.
- Reset mid-operation: in-flight command aborted, no writeback, no response.
- cmd_ready = (state==IDLE). A command is accepted on an edge with cmd_valid & cmd_ready.
- Accept, ALU op (cmd_load=0):
  - ALU_A <= rf[cmd_srca].
  - ALU_B <= cmd_use_imm ? cmd_imm : rf[cmd_srcb].
  - ALU_SEL <= cmd_op.
  - Latch dst and flags; go to ISSUE.
  - Operands come from register-file state before that edge.
- Accept, load (cmd_load=1):
  - rf[cmd_dst] <= cmd_imm.
  - rsp_data <= cmd_imm, rsp_dst <= cmd_dst, rsp_dz <= 0.
  - Go directly to RESP. ALU_* outputs are unchanged.
- ISSUE, one cycle: ALU_* are stable for the whole cycle. At the ending edge:
  - Divide-by-zero (ALU_SEL==011 and ALU_B==0): result = DZ_VALUE, rsp_dz <= 1.
  - Otherwise: result = ALU_OUT, truncated to DW by the ALU (ADD/SUB/MUL wrap mod 2^DW), rsp_dz <= 0.
  - rf[dst] <= result, rsp_data <= result, rsp_dst <= dst; go to RESP.
- RESP: rsp_valid=1.
  - rsp_data/rsp_dst/rsp_dz are held stable while rsp_valid & !rsp_ready.
  - On an edge with rsp_ready=1, go to IDLE; rsp_valid drops on the next cycle.
- Latency:
  - ALU op: accept at edge 0, ISSUE in cycle 1, rsp_valid in cycle 2.
  - Load: rsp_valid in cycle 1.
  - With rsp_ready held high: 3 cycles per ALU op, 2 per load.
- No hazards: writeback completes before the next accept.
  - dst==srca/srcb is legal; the old value is read and the new value is written.
  - cmd_valid in ISSUE/RESP is ignored, and the command is held by the producer.
- ALU_* outputs keep their last values in IDLE and RESP; they do not return to zero.

Test Plan:
Bench instantiates the team's 8-bit ALU between ALU_* ports and ALU_OUT.
1. Load R0=200, R1=100. ADD dst=R2, a=R0, b=R1 -> rsp_data=44 (300 mod 256), rsp_dst=2, rsp_dz=0, rsp_valid exactly 2 cycles after accept.
2. SUB R1-R0 -> 156. MUL with R0=20 and imm 13 -> 4 (260 mod 256). DIV 200/imm 7 -> 28. XNOR 8'hF0, 8'h0F -> 8'h00. Register file holds each result.
3. DIV R0 by imm 0 -> rsp_data=8'hFF, rsp_dz=1, rf[dst]=8'hFF. Next DIV by 5 -> rsp_dz=0.
4. Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/data/dst/dz stable, cmd_ready=0, a concurrent cmd_valid is not accepted. rsp_ready=1 -> IDLE next cycle.
5. Self-reference: R3=9, ADD dst=R3, a=R3, b=R3 -> rsp_data=18; next ADD R3+R3 -> 36.
6. RST=1 during ISSUE of ADD into R2 (old value 44) -> no response, rf[2] read back later =0 (reset clears), ALU_SEL=000, cmd_ready=1 the cycle after reset deasserts.
